int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 143 ++++++++++++++
 tb/tb_int_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Six-source interrupt controller feeding CP0 HWInt: per-source edge/level mode,
// enable mask, fixed-priority delivery (lowest index wins) and a take/eret handshake.
module int_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  dev_irq,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   input  logic        int_taken,
   input  logic        eret,
   output logic [5:0]  HWInt,
   output logic [2:0]  int_id,
   output logic [31:0] rdata,
   output logic        busy
);

   // state   | meaning
   // IDLE    | no request outstanding, arbitrating the candidate set
   // DELIVER | HWInt driven with onehot(id), waiting for int_taken or withdrawal
   // SERVICE | CP0 is running the handler for id, waiting for eret
   // BAD     | unused encoding, falls back to IDLE
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELIVER = 2'd1,
      SERVICE = 2'd2,
      BAD     = 2'd3
   } state_t;

   state_t      state;
   logic [5:0]  mode;
   logic [5:0]  enable;
   logic [5:0]  pend_edge;
   logic [5:0]  dev_q;
   logic [5:0]  dev_prev;
   logic [2:0]  id;

   logic [5:0]  pend;
   logic [5:0]  cand;
   logic [5:0]  rise;
   logic [5:0]  take_clr;
   logic [5:0]  pend_clr;
   logic [2:0]  win;
   logic [2:0]  status_id;
   logic        unused_wdata;

   assign unused_wdata = ^wdata[31:6];

   // Level sources pend straight from the synchronised pin; edge sources from the sticky bits.
   assign pend     = (pend_edge & mode) | (dev_q & ~mode);
   assign cand     = pend & enable;
   assign rise     = dev_q & ~dev_prev & mode;
   assign take_clr = (state == DELIVER && int_taken) ? (6'b000001 << id) : 6'b0;
   assign pend_clr = ((we && addr == 2'd2) ? wdata[5:0] : 6'b0) | take_clr;

   always_comb begin
      win = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (cand[i]) win = i[2:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mode      <= 6'b0;
         enable    <= 6'b0;
         pend_edge <= 6'b0;
         dev_q     <= 6'b0;
         dev_prev  <= 6'b0;
      end else begin
         dev_q     <= dev_irq;
         dev_prev  <= dev_q;
         pend_edge <= ((pend_edge & ~pend_clr) | rise) & mode;
         if (we && addr == 2'd0) mode   <= wdata[5:0];
         if (we && addr == 2'd1) enable <= wdata[5:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         id     <= 3'd0;
         HWInt  <= 6'b0;
         int_id <= 3'd7;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cand != 6'b0) begin
                  state  <= DELIVER;
                  id     <= win;
                  HWInt  <= 6'b000001 << win;
                  int_id <= win;
                  busy   <= 1'b1;
               end else begin
                  HWInt  <= 6'b0;
                  int_id <= 3'd7;
                  busy   <= 1'b0;
               end
            end
            DELIVER: begin
               if (int_taken) begin
                  state <= SERVICE;
                  HWInt <= 6'b0;
               end else if (!cand[id]) begin
                  state  <= IDLE;
                  HWInt  <= 6'b0;
                  int_id <= 3'd7;
                  busy   <= 1'b0;
               end
            end
            SERVICE: begin
               if (eret) begin
                  state  <= IDLE;
                  int_id <= 3'd7;
                  busy   <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               HWInt  <= 6'b0;
               int_id <= 3'd7;
               busy   <= 1'b0;
            end
         endcase
      end
   end

   // The id field reads 0 while idle so that STATUS is all-zero out of reset.
   assign status_id = busy ? int_id : 3'd0;

   always_comb begin
      rdata = 32'b0;
      case (addr)
         2'd0: rdata = {26'b0, mode};
         2'd1: rdata = {26'b0, enable};
         2'd2: rdata = {26'b0, pend};
         2'd3: rdata = {26'b0, state, status_id, busy};
         default: rdata = 32'b0;
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus randomized rounds; expected deliveries are
// queued by the stimulus and checked by a separate HWInt monitor.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  dev_irq = 6'b0;
   logic [1:0]  addr = 2'd0;
   logic        we = 1'b0;
   logic [31:0] wdata = 32'b0;
   logic        int_taken = 1'b0;
   logic        eret = 1'b0;
   logic [5:0]  HWInt;
   logic [2:0]  int_id;
   logic [31:0] rdata;
   logic        busy;

   int n_pass = 0;
   int n_total = 0;
   int exp_q[$];
   logic [5:0] prev_hw = 6'b0;

   int_ctrl dut (
      .clk(clk), .reset(reset), .dev_irq(dev_irq), .addr(addr), .we(we), .wdata(wdata),
      .int_taken(int_taken), .eret(eret), .HWInt(HWInt), .int_id(int_id), .rdata(rdata),
      .busy(busy)
   );

   always #10 clk = ~clk;

   // Each new request on HWInt must match the next queued source id.
   always @(negedge clk) begin
      int e;
      if (HWInt != 6'b0 && prev_hw == 6'b0) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_delivery: HWInt=%0h int_id=%0d, required no delivery", HWInt, int_id);
         end else begin
            e = exp_q.pop_front();
            if (HWInt == (6'b000001 << e) && int_id == e[2:0]) n_pass++;
            else $display("FAIL delivery: HWInt=%0h int_id=%0d, required HWInt=%0h int_id=%0d",
                          HWInt, int_id, 6'b000001 << e, e);
         end
      end
      prev_hw <= HWInt;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(name, rdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      step();
      we = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0; dev_irq = 6'b0; int_taken = 1'b0; eret = 1'b0; we = 1'b0;
      step(); step();
      reset = 1'b1;
   endtask

   task automatic take_and_return(input logic [5:0] irq_after);
      int_taken = 1'b1; dev_irq = irq_after;
      step();
      int_taken = 1'b0; eret = 1'b1;
      step();
      eret = 1'b0;
   endtask

   initial begin
      logic [5:0] pat, md, en, hit;
      int w;

      // Reset state
      do_reset();
      chk_reg("rst_mode", 2'd0, 32'h0);
      chk_reg("rst_enable", 2'd1, 32'h0);
      chk_reg("rst_pend", 2'd2, 32'h0);
      chk_reg("rst_status", 2'd3, 32'h0);
      chk("rst_hwint", HWInt, 32'h0);
      chk("rst_int_id", int_id, 32'd7);
      chk("rst_busy", busy, 32'h0);

      // Edge delivery, 3-edge latency
      wr(2'd0, 32'h3F); wr(2'd1, 32'h04);
      chk_reg("mode_rb", 2'd0, 32'h3F);
      exp_q.push_back(2);
      dev_irq = 6'h04; step(); dev_irq = 6'h00;
      chk("edge_lat1", HWInt, 32'h0);
      step();
      chk("edge_lat2", HWInt, 32'h0);
      chk_reg("edge_pend", 2'd2, 32'h04);
      step();
      chk("edge_hwint", HWInt, 32'h04);
      chk("edge_id", int_id, 32'd2);
      int_taken = 1'b1; step(); int_taken = 1'b0;
      chk("edge_taken_hwint", HWInt, 32'h0);
      chk_reg("edge_taken_pend", 2'd2, 32'h0);
      chk("edge_service_busy", busy, 32'h1);
      chk("edge_service_id", int_id, 32'd2);
      eret = 1'b1; step(); eret = 1'b0;
      chk("edge_eret_busy", busy, 32'h0);
      chk("edge_eret_id", int_id, 32'd7);

      // Priority among level sources, eret ignored in DELIVER
      do_reset();
      wr(2'd1, 32'h3F);
      exp_q.push_back(3); exp_q.push_back(5);
      dev_irq = 6'h28; step(); step();
      chk("prio_first", HWInt, 32'h08);
      eret = 1'b1; step(); eret = 1'b0;
      chk("prio_eret_ignored", HWInt, 32'h08);
      int_taken = 1'b1; dev_irq = 6'h20; step(); int_taken = 1'b0;
      chk("prio_service", HWInt, 32'h0);
      eret = 1'b1; step(); eret = 1'b0;
      chk("prio_idle_gap", HWInt, 32'h0);
      step();
      chk("prio_second", HWInt, 32'h20);
      chk("prio_second_id", int_id, 32'd5);
      take_and_return(6'h00);

      // Withdrawal of a level source; int_taken in IDLE ignored
      do_reset();
      int_taken = 1'b1; step(); int_taken = 1'b0;
      chk("taken_idle_ignored", busy, 32'h0);
      wr(2'd1, 32'h02);
      exp_q.push_back(1);
      dev_irq = 6'h02; step(); step();
      chk("wd_deliver", HWInt, 32'h02);
      dev_irq = 6'h00; step(); step();
      chk("wd_hwint", HWInt, 32'h0);
      chk("wd_busy", busy, 32'h0);
      chk_reg("wd_status", 2'd3, 32'h0);

      // W1C on edge pend, and set beating clear in the same cycle
      do_reset();
      wr(2'd0, 32'h01);
      dev_irq = 6'h01; step(); dev_irq = 6'h00; step();
      chk_reg("w1c_set", 2'd2, 32'h01);
      wr(2'd2, 32'h01);
      chk_reg("w1c_clear", 2'd2, 32'h0);
      dev_irq = 6'h01; step(); dev_irq = 6'h00; step();
      dev_irq = 6'h01; step(); dev_irq = 6'h00;
      wr(2'd2, 32'h01);
      chk_reg("set_wins", 2'd2, 32'h01);

      // Masked pend then enable
      do_reset();
      wr(2'd0, 32'h10);
      dev_irq = 6'h10; step(); dev_irq = 6'h00; step(); step();
      chk_reg("mask_pend", 2'd2, 32'h10);
      chk("mask_hwint", HWInt, 32'h0);
      exp_q.push_back(4);
      wr(2'd1, 32'h10);
      chk("mask_write_edge", HWInt, 32'h0);
      step();
      chk("mask_deliver", HWInt, 32'h10);
      take_and_return(6'h00);

      // Reset mid-SERVICE
      do_reset();
      wr(2'd0, 32'h3E); wr(2'd1, 32'h01);
      exp_q.push_back(0);
      dev_irq = 6'h01; step(); step();
      chk("rs_deliver", HWInt, 32'h01);
      int_taken = 1'b1; step(); int_taken = 1'b0;
      chk_reg("rs_status_service", 2'd3, 32'h21);
      reset = 1'b0; step(); reset = 1'b1;
      chk_reg("rs_status", 2'd3, 32'h0);
      chk_reg("rs_mode", 2'd0, 32'h0);
      chk_reg("rs_enable", 2'd1, 32'h0);
      chk_reg("rs_pend", 2'd2, 32'h0);
      chk("rs_int_id", int_id, 32'd7);
      chk("rs_busy", busy, 32'h0);
      chk("rs_hwint", HWInt, 32'h0);
      dev_irq = 6'h00;

      // Randomized rounds: all sources arrive together, then serviced in priority order
      for (int r = 0; r < 40; r++) begin
         do_reset();
         pat = 6'($urandom_range(1, 63));
         md  = 6'($urandom);
         en  = 6'($urandom);
         wr(2'd0, {26'b0, md});
         wr(2'd1, {26'b0, en});
         hit = pat & en;
         for (int k = 0; k < 6; k++) if (hit[k]) exp_q.push_back(k);
         // Edge bits one cycle ahead so both kinds become pending on the same edge.
         dev_irq = pat & md; step();
         dev_irq = pat & ~md;
         for (int k = 0; k < 6; k++) begin
            if (hit[k]) begin
               w = 0;
               while (HWInt == 6'b0 && w < 20) begin step(); w++; end
               if (HWInt == 6'b0) begin
                  n_total++;
                  $display("FAIL rand_wait round %0d: HWInt=0, required %0h", r, 6'b000001 << k);
               end
               take_and_return(md[k] ? dev_irq : (dev_irq & ~(6'b000001 << k)));
            end
         end
         repeat (6) step();
         chk_reg("rand_pend_left", 2'd2, {26'b0, pat & ~en});
         chk("rand_idle_busy", busy, 32'h0);
      end

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
